stream_arbiter: RTL and testbench
=================================

// Module: stream_arbiter
// PURPOSE
//  Round-robin arbiter that merges N_INPUTS 32-bit stb/ack producer streams onto one
//  shared stb/ack consumer stream, e.g. several main_N processes onto rs232_tx or leds.
//  Instantiated in user_design between process outputs and the shared output port.
//  Grants are held for up to BURST consecutive words, then rotate fairly.
//  A stall watchdog raises exception for OR-ing into the design exception.
// PARAMETERS
//  N_INPUTS   4    number of requesting streams (2..16)
//  WIDTH      32   data width of every stream
//  IDX_WIDTH  2    width of grant index; must satisfy 2**IDX_WIDTH >= N_INPUTS
//  BURST      4    max words accepted from one input per grant (>=1)
//  TIMEOUT    1024 stall cycles (output_out_stb high, ack low) before exception; 0 disables
// PORTS
//  clk                input  1                  clock, all state on rising edge
//  rst                input  1                  asynchronous reset, active-low
//  exception          output 1                  sticky watchdog flag
//  input_in           input  N_INPUTS*WIDTH     packed data, input i at [i*WIDTH +: WIDTH]
//  input_in_stb       input  N_INPUTS           producer i has a word valid
//  input_in_ack       output N_INPUTS           arbiter accepts producer i word
//  output_out         output WIDTH              merged data
//  output_out_stb     output 1                  merged word valid
//  output_out_ack     input  1                  consumer accepts word
//  output_grant       output IDX_WIDTH          source index of word on output_out
// BEHAVIOUR
//  Handshake: word transfers on a rising edge where stb and ack are both high.
//   Producers hold stb/data until acked; arbiter holds output_out_stb/data until acked.
//  Reset (rst low, async): state=IDLE, all input_in_ack=0, output_out_stb=0,
//   output_out=0, output_grant=0, ptr=0, burst count=0, stall count=0, exception=0.
//  All outputs are registered; at most one input_in_ack bit is high in any cycle.
//  IDLE: if any input_in_stb, grant = first i with stb set, searching ptr, ptr+1, ...
//   wrapping modulo N_INPUTS; register grant, set input_in_ack[grant]=1, go ACCEPT.
//   No stb: stay IDLE.
//  ACCEPT: when input_in_stb[grant]: latch data into output_out, output_grant=grant,
//   input_in_ack=0, output_out_stb=1, go SEND. Else hold ack high, stay.
//  SEND: when output_out_ack: output_out_stb=0, count=count+1. If count+1<BURST and
//   input_in_stb[grant] is high: set input_in_ack[grant]=1, go ACCEPT (grant retained).
//   Otherwise ptr = (grant+1) mod N_INPUTS, count=0, go IDLE.
//  Latency: stb seen in IDLE at cycle 0 -> ack high cycle 1 -> output_out_stb cycle 2.
//   Sustained same-input burst: one word per 2 cycles when consumer acks immediately.
//  Fairness: a continuously requesting input waits at most (N_INPUTS-1)*BURST words.
//  Single requester: re-granted after IDLE; BURST limit only inserts IDLE cycles.
//  Requests arriving during another grant are ignored until next IDLE evaluation.
//  ptr wraps from N_INPUTS-1 to 0; grant indices >= N_INPUTS are never produced.
//  Watchdog: stall count increments each cycle output_out_stb=1 and output_out_ack=0,
//   clears on transfer or when stb low; when it reaches TIMEOUT, exception=1 and
//   stays 1 until reset. Arbitration continues normally after exception.
//  Reset mid-transfer: any latched word is discarded; producers see ack drop async.
// TESTING
//  T1 single input 2 stb with 0xA5A5_0001, ack always 1 -> ack[2] cycle 1, out=0xA5A5_0001
//     stb cycle 2, output_grant=2; exactly one input transfer, one output transfer.
//  T2 all 4 inputs streaming 8 words each (tagged i<<16|n), BURST=4, ack=1 -> output order
//     in0 w0-3, in1 w0-3, in2 w0-3, in3 w0-3, in0 w4-7, ...; 32 words, none lost/duplicated.
//  T3 inputs 1 and 3 request, ptr=2 after in1 grant -> in3 granted before in1; ptr wraps to 0.
//  T4 consumer ack random 30% duty, random producers, 1000 words -> per-input order preserved,
//     output_out/output_grant stable while stb high and ack low, one-hot-or-zero input_in_ack.
//  T5 TIMEOUT=16, ack held 0 with stb high -> exception=1 exactly on 16th stall cycle; stays
//     1 after ack resumes; traffic drains.
//  T6 assert rst low while in SEND -> output_out_stb, input_in_ack, exception 0 immediately;
//     after release, next request granted from input 0 search start.

Source files
------------

// File: rtl/stream_arbiter.sv
// Round-robin merge of N_INPUTS stb/ack producer streams onto one consumer stream,
// with per-grant burst limit and a sticky stall watchdog.
//
// state  | meaning
// IDLE   | no grant; search requesters starting at ptr
// ACCEPT | input_in_ack[grant] high, waiting for the producer word
// SEND   | word held on output_out until the consumer acks
module stream_arbiter #(
  parameter int N_INPUTS  = 4,
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 2,
  parameter int BURST     = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      exception,
  input  logic [N_INPUTS*WIDTH-1:0] input_in,
  input  logic [N_INPUTS-1:0]       input_in_stb,
  output logic [N_INPUTS-1:0]       input_in_ack,
  output logic [WIDTH-1:0]          output_out,
  output logic                      output_out_stb,
  input  logic                      output_out_ack,
  output logic [IDX_WIDTH-1:0]      output_grant
);

  localparam int NSLOT = 1 << IDX_WIDTH;
  localparam int BC_W  = $clog2(BURST + 1);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, SEND} state_t;

  state_t               state, state_nx;
  logic [IDX_WIDTH-1:0] grant, grant_nx;
  logic [IDX_WIDTH-1:0] ptr, ptr_nx;
  logic [BC_W-1:0]      burst_cnt, burst_nx;
  logic [BC_W:0]        burst_inc;
  logic [N_INPUTS-1:0]  ack_nx;
  logic [WIDTH-1:0]     out_nx;
  logic                 out_stb_nx;
  logic [IDX_WIDTH-1:0] out_grant_nx;
  logic [WD_W-1:0]      stall_left;

  logic [NSLOT-1:0]     stb_ext;
  logic [NSLOT-1:0]     hot_pick, hot_grant;
  logic [WIDTH-1:0]     in_words [NSLOT];
  logic                 found;
  logic [IDX_WIDTH-1:0] pick;
  logic [IDX_WIDTH:0]   sum;

  // Pad the request/data view to a power of two so grant-indexed selects stay in range.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < N_INPUTS) begin : g_used
      assign in_words[i] = input_in[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign in_words[i] = '0;
    end
  end

  assign stb_ext   = NSLOT'(input_in_stb);
  assign hot_pick  = NSLOT'(1) << pick;
  assign hot_grant = NSLOT'(1) << grant;
  assign burst_inc = {1'b0, burst_cnt} + 1'b1;

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    sum   = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      sum = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (sum >= (IDX_WIDTH+1)'(N_INPUTS)) sum = sum - (IDX_WIDTH+1)'(N_INPUTS);
      if (!found && stb_ext[sum[IDX_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = sum[IDX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    ptr_nx       = ptr;
    burst_nx     = burst_cnt;
    ack_nx       = input_in_ack;
    out_nx       = output_out;
    out_stb_nx   = output_out_stb;
    out_grant_nx = output_grant;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = pick;
          ack_nx   = hot_pick[N_INPUTS-1:0];
          state_nx = ACCEPT;
        end
      end
      ACCEPT: begin
        if (stb_ext[grant]) begin
          out_nx       = in_words[grant];
          out_grant_nx = grant;
          ack_nx       = '0;
          out_stb_nx   = 1'b1;
          state_nx     = SEND;
        end
      end
      SEND: begin
        if (output_out_ack) begin
          out_stb_nx = 1'b0;
          if (burst_inc < (BC_W+1)'(BURST) && stb_ext[grant]) begin
            ack_nx   = hot_grant[N_INPUTS-1:0];
            burst_nx = burst_inc[BC_W-1:0];
            state_nx = ACCEPT;
          end else begin
            ptr_nx   = (grant == IDX_WIDTH'(N_INPUTS - 1)) ? '0 : grant + 1'b1;
            burst_nx = '0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      grant          <= '0;
      ptr            <= '0;
      burst_cnt      <= '0;
      input_in_ack   <= '0;
      output_out     <= '0;
      output_out_stb <= 1'b0;
      output_grant   <= '0;
    end else begin
      state          <= state_nx;
      grant          <= grant_nx;
      ptr            <= ptr_nx;
      burst_cnt      <= burst_nx;
      input_in_ack   <= ack_nx;
      output_out     <= out_nx;
      output_out_stb <= out_stb_nx;
      output_grant   <= out_grant_nx;
    end
  end

  // Down-counter reloads whenever the output is not stalled; terminal count latches the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_left <= WD_W'(TIMEOUT);
      exception  <= 1'b0;
    end else if (TIMEOUT != 0) begin
      if (output_out_stb && !output_out_ack) begin
        if (stall_left == WD_W'(1)) exception <= 1'b1;
        else stall_left <= stall_left - 1'b1;
      end else begin
        stall_left <= WD_W'(TIMEOUT);
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: producer queues feed a scoreboard of accepted
// words, which is compared against every consumer-side transfer.
module tb_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         exception;
  logic [127:0] input_in = '0;
  logic [3:0]   input_in_stb = '0;
  logic [3:0]   input_in_ack;
  logic [31:0]  output_out;
  logic         output_out_stb;
  logic         output_out_ack = 1'b0;
  logic [1:0]   output_grant;

  int n_tests = 0;
  int n_fail  = 0;
  int n_in    = 0;
  int n_out   = 0;

  logic [31:0] prod_q [4][$];
  logic [31:0] sb_data[$];
  logic [1:0]  sb_grant[$];
  logic [31:0] exp_order[$];
  bit          rand_prod = 1'b0;
  bit          rand_cons = 1'b0;
  logic        cons_ack  = 1'b1;

  always #5 clk = ~clk;

  stream_arbiter #(
    .N_INPUTS(4), .WIDTH(32), .IDX_WIDTH(2), .BURST(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .exception(exception),
    .input_in(input_in), .input_in_stb(input_in_stb), .input_in_ack(input_in_ack),
    .output_out(output_out), .output_out_stb(output_out_stb),
    .output_out_ack(output_out_ack), .output_grant(output_grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++)
      if (!input_in_stb[i] && prod_q[i].size() != 0) begin
        input_in_stb[i]       = 1'b1;
        input_in[i*32 +: 32]  = prod_q[i][0];
      end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) prod_q[i].delete();
    sb_data.delete();
    sb_grant.delete();
    exp_order.delete();
    input_in_stb = '0;
    input_in     = '0;
  endtask

  // One clock: observe handshakes that happened on this edge, then drive the next cycle.
  task automatic step();
    logic [3:0]  p_stb, p_ack;
    logic        p_ostb, p_oack;
    logic [31:0] p_out, d;
    logic [1:0]  p_gr, g;
    p_stb  = input_in_stb;
    p_ack  = input_in_ack;
    p_ostb = output_out_stb;
    p_oack = output_out_ack;
    p_out  = output_out;
    p_gr   = output_grant;
    @(posedge clk);
    #1;
    check("ack_onehot0", $onehot0(input_in_ack), 1);
    if (p_ostb && !p_oack) begin
      check("hold_stb", output_out_stb, 1);
      check("hold_data", output_out, p_out);
      check("hold_grant", output_grant, p_gr);
    end
    if (p_ostb && p_oack) begin
      n_out++;
      check("sb_nonempty", sb_data.size() != 0, 1);
      if (sb_data.size() != 0) begin
        d = sb_data.pop_front();
        g = sb_grant.pop_front();
        check("out_data", p_out, d);
        check("out_grant", p_gr, g);
      end
      if (exp_order.size() != 0) check("order", p_out, exp_order.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (p_stb[i] && p_ack[i] && prod_q[i].size() != 0) begin
        n_in++;
        sb_data.push_back(prod_q[i].pop_front());
        sb_grant.push_back(2'(i));
      end
      if (!(input_in_stb[i] && !(p_stb[i] && p_ack[i]))) begin
        if (prod_q[i].size() != 0 && (!rand_prod || $urandom_range(0, 1) == 1)) begin
          input_in_stb[i]      = 1'b1;
          input_in[i*32 +: 32] = prod_q[i][0];
        end else begin
          input_in_stb[i] = 1'b0;
        end
      end
    end
    output_out_ack = rand_cons ? ($urandom_range(0, 99) < 30) : cons_ack;
  endtask

  task automatic run_until(input int target, input int budget);
    int c = 0;
    while (n_out < target && c < budget) begin
      step();
      c++;
    end
    check("drain_count", n_out, target);
  endtask

  task automatic wait_stb(input int budget);
    int c = 0;
    while (!output_out_stb && c < budget) begin
      step();
      c++;
    end
    check("wait_out_stb", output_out_stb, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int in0, out0, tgt;
    #12;
    check("rst_out_stb", output_out_stb, 0);
    check("rst_in_ack", input_in_ack, 0);
    check("rst_out", output_out, 0);
    check("rst_grant", output_grant, 0);
    check("rst_exception", exception, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: single word from input 2, exact latency
    cons_ack = 1'b1;
    output_out_ack = 1'b1;
    in0 = n_in;
    out0 = n_out;
    prod_q[2].push_back(32'hA5A5_0001);
    refresh();
    step();
    check("t1_ack_c1", input_in_ack, 4'b0100);
    check("t1_stb_c1", output_out_stb, 0);
    step();
    check("t1_stb_c2", output_out_stb, 1);
    check("t1_data_c2", output_out, 32'hA5A5_0001);
    check("t1_grant_c2", output_grant, 2);
    check("t1_ack_c2", input_in_ack, 0);
    step();
    check("t1_stb_c3", output_out_stb, 0);
    step();
    step();
    check("t1_in_count", n_in - in0, 1);
    check("t1_out_count", n_out - out0, 1);

    // T2: four streaming inputs, 8 words each, bursts of 4 rotating
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 8; n++) prod_q[i].push_back((i << 16) | n);
    for (int j = 0; j < 32; j++)
      exp_order.push_back((((j % 16) / 4) << 16) | ((j / 16) * 4 + j % 4));
    refresh();
    run_until(n_out + 32, 400);
    check("t2_order_done", exp_order.size(), 0);
    check("t2_sb_empty", sb_data.size(), 0);

    // T3: ptr moves past input 1 so input 3 wins, then wraps to 0
    for (int n = 0; n < 6; n++) prod_q[1].push_back((1 << 16) | n);
    prod_q[3].push_back(3 << 16);
    for (int n = 0; n < 4; n++) exp_order.push_back((1 << 16) | n);
    exp_order.push_back(3 << 16);
    exp_order.push_back((1 << 16) | 4);
    exp_order.push_back((1 << 16) | 5);
    refresh();
    run_until(n_out + 7, 200);
    check("t3_order_done", exp_order.size(), 0);
    prod_q[0].push_back(32'h0000_0020);
    prod_q[3].push_back(32'h0003_0020);
    exp_order.push_back(32'h0003_0020);
    exp_order.push_back(32'h0000_0020);
    refresh();
    run_until(n_out + 2, 100);
    check("t3_wrap_done", exp_order.size(), 0);

    // T5: watchdog fires on the 16th stall cycle and stays set
    cons_ack = 1'b0;
    output_out_ack = 1'b0;
    tgt = n_out + 1;
    prod_q[2].push_back(32'h0002_0030);
    refresh();
    wait_stb(10);
    for (int k = 0; k < 15; k++) step();
    check("t5_exc_15", exception, 0);
    step();
    check("t5_exc_16", exception, 1);
    cons_ack = 1'b1;
    output_out_ack = 1'b1;
    run_until(tgt, 50);
    check("t5_exc_sticky", exception, 1);

    // T6: asynchronous reset while holding a word in SEND
    cons_ack = 1'b0;
    output_out_ack = 1'b0;
    prod_q[0].push_back(32'h0000_0040);
    refresh();
    wait_stb(10);
    #2;
    rst = 1'b0;
    #1;
    check("t6_out_stb", output_out_stb, 0);
    check("t6_in_ack", input_in_ack, 0);
    check("t6_exception", exception, 0);
    check("t6_out", output_out, 0);
    clear_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cons_ack = 1'b1;
    output_out_ack = 1'b1;
    prod_q[3].push_back(32'h0003_0040);
    prod_q[1].push_back(32'h0001_0040);
    exp_order.push_back(32'h0001_0040);
    exp_order.push_back(32'h0003_0040);
    refresh();
    run_until(n_out + 2, 100);
    check("t6_order_done", exp_order.size(), 0);

    // T4: random producers and 30% consumer ack, 1000 words
    rand_prod = 1'b1;
    rand_cons = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 250; n++) prod_q[i].push_back((i << 16) | (32'h100 + n));
    run_until(n_out + 1000, 40000);
    check("t4_sb_empty", sb_data.size(), 0);
    check("t4_prod_empty",
          prod_q[0].size() + prod_q[1].size() + prod_q[2].size() + prod_q[3].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
